// File: rtl/mp_cache_types.sv
// Shared types and widths for the data cache and its memory-side adapter.
package mp_cache_types;

    localparam int LINE_WIDTH = 256;
    localparam int BEAT_WIDTH = 64;
    localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        WRITE_BURST,
        READ_REQ,
        READ_WAIT,
        READ_DONE
    } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Converts single cache-line reads/writes into 4-beat bmem bursts and
// reassembles read beats into a line. One transaction in flight at a time.
module cacheline_adapter #(
    parameter int LINE_WIDTH = mp_cache_types::LINE_WIDTH,
    parameter int BEAT_WIDTH = mp_cache_types::BEAT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [31:0]           dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic                  dfp_ready,
    output logic [31:0]           dfp_raddr,
    output logic [LINE_WIDTH-1:0] dfp_rdata,
    output logic                  dfp_rvalid,

    output logic [31:0]           bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [31:0]           bmem_raddr,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid
);
    import mp_cache_types::*;

    localparam int BEAT_COUNT = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W      = $clog2(BEAT_COUNT);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEAT_COUNT - 1);

    adapter_state_t        state, state_next;
    logic [CNT_W-1:0]      cnt;
    logic [31:0]           addr_q;
    logic [LINE_WIDTH-1:0] line_q;
    logic [31:0]           raddr_q;
    logic [LINE_WIDTH-1:0] rdata_q;

    logic beat_hit;
    logic last_beat;

    assign beat_hit  = (state == READ_WAIT) && bmem_rvalid && (bmem_raddr == addr_q);
    assign last_beat = (cnt == LAST_BEAT);

    // NOTE: every variable in this block gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (dfp_write)     state_next = WRITE_BURST;
                else if (dfp_read) state_next = READ_REQ;
            end
            WRITE_BURST: if (last_beat)             state_next = IDLE;
            READ_REQ:    if (bmem_ready)            state_next = READ_WAIT;
            READ_WAIT:   if (beat_hit && last_beat) state_next = READ_DONE;
            READ_DONE:                              state_next = IDLE;
            default:                                state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: the line buffers are plain flops, not RAM, so resetting them is
    // cheap and guarantees the returned line reads as zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            raddr_q <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dfp_write) begin
                        addr_q <= dfp_addr;
                        line_q <= dfp_wdata;
                        cnt    <= '0;
                    end else if (dfp_read) begin
                        addr_q <= dfp_addr;
                        cnt    <= '0;
                    end
                end
                // Beat 0 waits for the memory handshake; later beats stream.
                WRITE_BURST: begin
                    if (cnt != '0 || bmem_ready) cnt <= cnt + 1'b1;
                end
                READ_REQ: begin
                    if (bmem_ready) cnt <= '0;
                end
                READ_WAIT: begin
                    if (beat_hit) begin
                        line_q[int'(cnt)*BEAT_WIDTH +: BEAT_WIDTH] <= bmem_rdata;
                        cnt <= cnt + 1'b1;
                        // Separate output copy keeps the last read line stable while
                        // line_q is reused by later writes or partial reads.
                        if (last_beat) begin
                            rdata_q <= {bmem_rdata, line_q[LINE_WIDTH-BEAT_WIDTH-1:0]};
                            raddr_q <= addr_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dfp_ready  = (state == IDLE);
    assign dfp_rvalid = (state == READ_DONE);
    assign dfp_raddr  = raddr_q;
    assign dfp_rdata  = rdata_q;

    assign bmem_write = (state == WRITE_BURST);
    assign bmem_read  = (state == READ_REQ);
    assign bmem_addr  = (bmem_write || bmem_read) ? addr_q : '0;
    assign bmem_wdata = bmem_write ? line_q[int'(cnt)*BEAT_WIDTH +: BEAT_WIDTH] : '0;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: per-cycle vector tables plus
// hand-written sequences for tag filtering, write priority and reset.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic         dfp_ready;
    logic [31:0]  dfp_raddr;
    logic [255:0] dfp_rdata;
    logic         dfp_rvalid;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int total = 0;
    int bad   = 0;
    int rvalid_cnt = 0;

    cacheline_adapter dut (
        .clk        (clk),
        .rst        (rst),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_write  (dfp_write),
        .dfp_wdata  (dfp_wdata),
        .dfp_ready  (dfp_ready),
        .dfp_raddr  (dfp_raddr),
        .dfp_rdata  (dfp_rdata),
        .dfp_rvalid (dfp_rvalid),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dfp_rvalid === 1'b1) rvalid_cnt++;

    typedef struct {
        logic        rd, wr, brdy, bvld;
        logic [31:0] btag;
        logic [63:0] bdat;
        logic        e_rdy, e_rvld, e_brd, e_bwr;
        logic [63:0] e_wdat;
        logic [31:0] e_badr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rd, wr, brdy, bvld,
                                input logic [31:0] btag, input logic [63:0] bdat,
                                input logic e_rdy, e_rvld, e_brd, e_bwr,
                                input logic [63:0] e_wdat, input logic [31:0] e_badr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.brdy = brdy; v.bvld = bvld;
        v.btag = btag; v.bdat = bdat;
        v.e_rdy = e_rdy; v.e_rvld = e_rvld; v.e_brd = e_brd; v.e_bwr = e_bwr;
        v.e_wdat = e_wdat; v.e_badr = e_badr;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
    endtask

    // Row i = cycle i: drive inputs, compare Moore outputs, then advance.
    task automatic run_vectors(input string label);
        for (int i = 0; i < tbl.size(); i++) begin
            dfp_read    = tbl[i].rd;
            dfp_write   = tbl[i].wr;
            bmem_ready  = tbl[i].brdy;
            bmem_rvalid = tbl[i].bvld;
            bmem_raddr  = tbl[i].btag;
            bmem_rdata  = tbl[i].bdat;
            check($sformatf("%s[%0d].dfp_ready", label, i),  dfp_ready,  tbl[i].e_rdy);
            check($sformatf("%s[%0d].dfp_rvalid", label, i), dfp_rvalid, tbl[i].e_rvld);
            check($sformatf("%s[%0d].bmem_read", label, i),  bmem_read,  tbl[i].e_brd);
            check($sformatf("%s[%0d].bmem_write", label, i), bmem_write, tbl[i].e_bwr);
            check($sformatf("%s[%0d].bmem_wdata", label, i), bmem_wdata, tbl[i].e_wdat);
            check($sformatf("%s[%0d].bmem_addr", label, i),  bmem_addr,  tbl[i].e_badr);
            tick();
        end
        tbl.delete();
        idle_inputs();
    endtask

    task automatic feed_beat(input logic [31:0] tag, input logic [63:0] data);
        bmem_rvalid = 1'b1;
        bmem_raddr  = tag;
        bmem_rdata  = data;
        tick();
        bmem_rvalid = 1'b0;
    endtask

    initial begin
        int base;
        idle_inputs();
        dfp_addr  = '0;
        dfp_wdata = '0;

        #2;
        check("reset.dfp_ready",  dfp_ready,  1'b1);
        check("reset.dfp_rvalid", dfp_rvalid, 1'b0);
        check("reset.bmem_read",  bmem_read,  1'b0);
        check("reset.bmem_write", bmem_write, 1'b0);
        check("reset.bmem_addr",  bmem_addr,  32'h0);
        check("reset.dfp_rdata",  dfp_rdata,  256'h0);
        tick();
        rst = 1'b0;
        tick();

        // Write, memory always ready.
        dfp_addr  = 32'h0000_1000;
        dfp_wdata = {64'h4, 64'h3, 64'h2, 64'h1};
        tbl.push_back(mk(0,1,1,0,0,0, 1,0,0,0,0,0));
        for (int k = 1; k <= 4; k++)
            tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,1,64'(k),32'h1000));
        tbl.push_back(mk(0,0,1,0,0,0, 1,0,0,0,0,0));
        run_vectors("wr_fast");

        // Write, beat 0 stalled; later beats must stream even with ready low.
        tbl.push_back(mk(0,1,0,0,0,0, 1,0,0,0,0,0));
        for (int k = 1; k <= 3; k++)
            tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,1,64'h1,32'h1000));
        tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,1,64'h1,32'h1000));
        for (int k = 2; k <= 4; k++)
            tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,1,64'(k),32'h1000));
        tbl.push_back(mk(0,0,0,0,0,0, 1,0,0,0,0,0));
        run_vectors("wr_stall");

        // Read with gaps: beats on cycles 3,5,6,9, rvalid on cycle 10.
        base = rvalid_cnt;
        dfp_addr = 32'h0000_2000;
        tbl.push_back(mk(1,0,1,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0, 0,0,1,0,0,32'h2000));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,32'h2000,64'hA, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,32'h2000,64'hB, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,32'h2000,64'hC, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,32'h2000,64'hD, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 1,0,0,0,0,0));
        run_vectors("rd_gaps");
        check("rd_gaps.dfp_raddr", dfp_raddr, 32'h2000);
        check("rd_gaps.dfp_rdata", dfp_rdata, {64'hD, 64'hC, 64'hB, 64'hA});
        check("rd_gaps.pulses", 32'(rvalid_cnt - base), 32'd1);

        // Read with a stalled request and a foreign-tagged beat interleaved.
        dfp_addr = 32'h0000_2000;
        dfp_read = 1'b1;
        tick();
        dfp_read = 1'b0;
        check("foreign.bmem_read_c1", bmem_read, 1'b1);
        tick();
        check("foreign.bmem_read_held", bmem_read, 1'b1);
        check("foreign.bmem_addr", bmem_addr, 32'h2000);
        bmem_ready = 1'b1;
        tick();
        bmem_ready = 1'b0;
        check("foreign.bmem_read_dropped", bmem_read, 1'b0);
        feed_beat(32'h2000, 64'h11);
        feed_beat(32'h3000, 64'hEE);
        feed_beat(32'h2000, 64'h22);
        feed_beat(32'h3000, 64'hEF);
        feed_beat(32'h2000, 64'h33);
        check("foreign.no_early_rvalid", dfp_rvalid, 1'b0);
        feed_beat(32'h2000, 64'h44);
        check("foreign.dfp_rvalid", dfp_rvalid, 1'b1);
        check("foreign.dfp_rdata", dfp_rdata, {64'h44, 64'h33, 64'h22, 64'h11});
        check("foreign.dfp_raddr", dfp_raddr, 32'h2000);
        tick();

        // Read and write together: write wins, held read follows the burst.
        dfp_addr   = 32'h0000_4000;
        dfp_wdata  = {64'h7777, 64'h6666, 64'h5555, 64'h4444};
        dfp_read   = 1'b1;
        dfp_write  = 1'b1;
        bmem_ready = 1'b1;
        tick();
        dfp_write = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("both.bmem_write[%0d]", k), bmem_write, 1'b1);
            check($sformatf("both.bmem_read[%0d]", k), bmem_read, 1'b0);
            check($sformatf("both.bmem_wdata[%0d]", k), bmem_wdata, 64'h4444 + 64'(k) * 64'h1111);
            tick();
        end
        check("both.dfp_ready_after_burst", dfp_ready, 1'b1);
        check("both.rdata_held_over_write", dfp_rdata, {64'h44, 64'h33, 64'h22, 64'h11});
        tick();
        dfp_read = 1'b0;
        check("both.bmem_read", bmem_read, 1'b1);
        check("both.bmem_read_addr", bmem_addr, 32'h4000);
        tick();
        bmem_ready = 1'b0;
        for (int k = 0; k < 4; k++) feed_beat(32'h4000, 64'h100 + 64'(k));
        check("both.dfp_rdata", dfp_rdata, {64'h103, 64'h102, 64'h101, 64'h100});
        tick();

        // Reset in READ_WAIT after two beats.
        dfp_addr   = 32'h0000_5000;
        dfp_read   = 1'b1;
        bmem_ready = 1'b1;
        tick();
        dfp_read = 1'b0;
        tick();
        bmem_ready = 1'b0;
        feed_beat(32'h5000, 64'h51);
        feed_beat(32'h5000, 64'h52);
        base = rvalid_cnt;
        #2 rst = 1'b1;
        #1;
        check("midrst.dfp_ready",  dfp_ready,  1'b1);
        check("midrst.dfp_rvalid", dfp_rvalid, 1'b0);
        check("midrst.bmem_read",  bmem_read,  1'b0);
        check("midrst.bmem_write", bmem_write, 1'b0);
        check("midrst.bmem_addr",  bmem_addr,  32'h0);
        check("midrst.dfp_rdata",  dfp_rdata,  256'h0);
        check("midrst.dfp_raddr",  dfp_raddr,  32'h0);
        tick();
        rst = 1'b0;
        feed_beat(32'h5000, 64'h53);
        feed_beat(32'h5000, 64'h54);
        tick();
        tick();
        check("midrst.no_rvalid", 32'(rvalid_cnt - base), 32'd0);
        check("midrst.idle", dfp_ready, 1'b1);

        dfp_addr   = 32'h0000_6000;
        dfp_read   = 1'b1;
        bmem_ready = 1'b1;
        tick();
        dfp_read = 1'b0;
        tick();
        bmem_ready = 1'b0;
        for (int k = 0; k < 4; k++) feed_beat(32'h6000, 64'h60 + 64'(k));
        check("post_rst.dfp_rvalid", dfp_rvalid, 1'b1);
        check("post_rst.dfp_raddr", dfp_raddr, 32'h6000);
        check("post_rst.dfp_rdata", dfp_rdata, {64'h63, 64'h62, 64'h61, 64'h60});
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Memory-side responder for the data cache's downstream port. It accepts one 256-bit line read or write from the cache, converts it into a 4-beat, 64-bit burst on the burst-memory (bmem) interface, and for reads assembles the returned beats into a line presented with `dfp_rvalid`/`dfp_raddr`. It sits between the dcache controller and the memory arbiter/bmem model. At most one transaction is in flight.

## Interface
- `LINE_WIDTH`, 256, cache line width in bits
- `BEAT_WIDTH`, 64, bmem beat width in bits; `BEATS = LINE_WIDTH/BEAT_WIDTH` (= 4)
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `dfp_addr` in 32: line address, bits [4:0] = 0
- `dfp_read` in 1: line read request
- `dfp_write` in 1: line write request
- `dfp_wdata` in LINE_WIDTH: write line
- `dfp_ready` out 1: request accepted this cycle if read|write is high
- `dfp_raddr` out 32: address of returned line
- `dfp_rdata` out LINE_WIDTH: returned line
- `dfp_rvalid` out 1: one-cycle pulse, read line valid
- `bmem_addr` out 32: burst address
- `bmem_read` out 1: burst read command
- `bmem_write` out 1: write beat valid
- `bmem_wdata` out BEAT_WIDTH: write beat
- `bmem_ready` in 1: memory can accept a command / first write beat
- `bmem_raddr` in 32: address tag of the read beat
- `bmem_rdata` in BEAT_WIDTH: read beat
- `bmem_rvalid` in 1: read beat valid

## Operation
- States: IDLE, WRITE_BURST, READ_REQ, READ_WAIT, READ_DONE.
- IDLE: `dfp_ready` = 1. If `dfp_write`, latch addr and wdata, then go to WRITE_BURST. Else if `dfp_read`, latch addr, then go to READ_REQ. When both are asserted, write wins and the read is not accepted.
- WRITE_BURST: `bmem_write` = 1, `bmem_addr` = latched addr, `bmem_wdata` = line[64*cnt +: 64], starting at cnt = 0.
  - Beat 0 advances only when `bmem_ready` = 1. Otherwise it holds with the same data.
  - Beats 1..3 advance unconditionally, one per cycle.
  - After beat 3, return to IDLE.
- READ_REQ: `bmem_read` = 1, `bmem_addr` = latched addr. When `bmem_ready` = 1, go to READ_WAIT and clear cnt.
- READ_WAIT: on `bmem_rvalid` && `bmem_raddr` == latched addr, store `bmem_rdata` in beat slot cnt and increment cnt.
  - Beats with a mismatched tag are ignored.
  - Gaps between beats are allowed.
  - When the beat with cnt = 3 is stored, go to READ_DONE.
- READ_DONE: `dfp_rvalid` = 1, `dfp_raddr` = latched addr, `dfp_rdata` = assembled line. Go to IDLE next cycle.
- `dfp_rdata`/`dfp_raddr` hold their values after READ_DONE until the next read completes. Only `dfp_rvalid` qualifies them.
- Beat ordering: beat k occupies line bits [64k+63:64k].
- cnt is 2 bits. It is cleared on each acceptance and must not wrap within a burst.

## Timing
- Reset (asynchronous): state IDLE, cnt 0, latched addr/data 0. All outputs are 0 except `dfp_ready`, which is 1.
- Reset mid-burst: the transaction is abandoned. Beats arriving after reset are ignored because state is IDLE. No `dfp_rvalid` is produced.
- Write latency, with `bmem_ready` = 1 throughout: accept at cycle 0, beats on cycles 1–4, `dfp_ready` = 1 at cycle 5.
- Read latency: accept at cycle 0, `bmem_read` at cycle 1. If the four beats arrive on cycles r..r+3, `dfp_rvalid` is high at cycle r+4. `dfp_ready` returns at r+5.
- `bmem_read` is held until `bmem_ready`. It is never asserted for more than the single accepting cycle once `bmem_ready` is seen.
- `bmem_write` and `bmem_read` are never high in the same cycle.
- `dfp_ready` is low in every state except IDLE. A request asserted then is held by the cache and accepted on return to IDLE.
- All outputs are decoded from registered state and registered data (Moore). `dfp_ready` does not depend combinationally on `dfp_read`/`dfp_write`.

## Structure
- Add `adapter_state_t` (IDLE, WRITE_BURST, READ_REQ, READ_WAIT, READ_DONE) to `mp_cache_types`.
- Add the `LINE_WIDTH`/`BEAT_WIDTH` constants to `mp_cache_types`.
- Single module, no sub-modules. It contains one FSM, a 2-bit beat counter, and a line/address register shared between read assembly and write source.

## Test plan
- Write A = 0x0000_1000, wdata = {64'h4, 64'h3, 64'h2, 64'h1}, `bmem_ready` = 1:
  - `bmem_write` high on cycles 1–4 with wdata 1, 2, 3, 4 and addr 0x1000.
  - `dfp_ready` = 1 at cycle 5.
- Same write with `bmem_ready` = 0 for cycles 1–3:
  - beat 0 = 1 held on cycles 1–4.
  - beats 2, 3, 4 on cycles 5–7.
- Read 0x0000_2000, beats 0xA, 0xB, 0xC, 0xD on cycles 3, 5, 6, 9:
  - `dfp_rvalid` pulses only at cycle 10, with `dfp_raddr` = 0x2000 and `dfp_rdata` = {D, C, B, A}.
- Read 0x2000 with an interleaved beat tagged 0x3000:
  - the foreign beat is ignored.
  - the line is still assembled from the four 0x2000 beats only.
- `dfp_read` and `dfp_write` both high at 0x4000:
  - a write burst occurs and no `bmem_read` is issued.
  - after the burst, a held `dfp_read` is accepted and a `bmem_read` is issued at 0x4000.
- Assert `rst` during READ_WAIT after 2 beats, then feed the remaining 2 beats:
  - all outputs are at reset values immediately.
  - no `dfp_rvalid` is produced.
  - the next read completes normally.
